// File: rtl/shift_issue_stage.sv
// Execute-stage issue front end for the 32-bit barrel shifter.
// Decodes the MIPS shift functs (sll/srl/sra/sllv/srlv/srav) from an R-type
// instruction and presents d/sa/right/arith/out_rd/out_illeg to the shifter.
// A main register M drives the outputs and a skid register S absorbs one
// extra entry, so in_ready can come straight from a flop.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Once a producer raises valid, it holds valid and its payload until the
// transfer. Ready may change freely. The payload on out_* is stable while
// out_valid is high and out_ready is low.
module shift_issue_stage #(
    parameter int DW  = 32,
    parameter int SAW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [5:0]     in_op,
    input  logic [5:0]     in_func,
    input  logic [SAW-1:0] in_shamt,
    input  logic [DW-1:0]  in_rs,
    input  logic [DW-1:0]  in_rt,
    input  logic [4:0]     in_rd,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  d,
    output logic [SAW-1:0] sa,
    output logic           right,
    output logic           arith,
    output logic [4:0]     out_rd,
    output logic           out_illeg
);

    // MIPS funct encodings for the shift group (op == 0)
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] F_SLL    = 6'b000000;
    localparam logic [5:0] F_SRL    = 6'b000010;
    localparam logic [5:0] F_SRA    = 6'b000011;
    localparam logic [5:0] F_SLLV   = 6'b000100;
    localparam logic [5:0] F_SRLV   = 6'b000110;
    localparam logic [5:0] F_SRAV   = 6'b000111;

    // One decoded shifter command
    typedef struct packed {
        logic [DW-1:0]  d;
        logic [SAW-1:0] sa;
        logic           right;
        logic           arith;
        logic [4:0]     rd;
        logic           illeg;
    } entry_t;

    entry_t dec_e;      // decode of the current input
    entry_t m_q;        // main register, drives the outputs
    entry_t s_q;        // skid register
    logic   m_valid;
    logic   s_valid;
    logic   in_ready_q;
    logic   in_fire;
    logic   out_fire;

    // Only the low SAW bits of rs select a variable shift amount
    logic unused_rs_hi;
    assign unused_rs_hi = ^in_rs[DW-1:SAW];

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = m_valid & out_ready;

    // Decode the incoming instruction into a shifter command
    always_comb begin
        dec_e       = '0;
        dec_e.d     = in_rt;
        dec_e.rd    = in_rd;
        dec_e.illeg = 1'b1;
        if (in_op == OP_RTYPE) begin
            case (in_func)
                F_SLL: begin
                    dec_e.sa    = in_shamt;
                    dec_e.illeg = 1'b0;
                end
                F_SRL: begin
                    dec_e.sa    = in_shamt;
                    dec_e.right = 1'b1;
                    dec_e.illeg = 1'b0;
                end
                F_SRA: begin
                    dec_e.sa    = in_shamt;
                    dec_e.right = 1'b1;
                    dec_e.arith = 1'b1;
                    dec_e.illeg = 1'b0;
                end
                F_SLLV: begin
                    dec_e.sa    = in_rs[SAW-1:0];
                    dec_e.illeg = 1'b0;
                end
                F_SRLV: begin
                    dec_e.sa    = in_rs[SAW-1:0];
                    dec_e.right = 1'b1;
                    dec_e.illeg = 1'b0;
                end
                F_SRAV: begin
                    dec_e.sa    = in_rs[SAW-1:0];
                    dec_e.right = 1'b1;
                    dec_e.arith = 1'b1;
                    dec_e.illeg = 1'b0;
                end
                default: begin
                    // Not a shift: pass rt through unchanged (sa=0, left)
                    dec_e.illeg = 1'b1;
                end
            endcase
        end
    end

    // Occupancy of M and S; in_ready is registered as the inverse of S-full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            s_valid    <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (s_valid) begin
            // in_ready is low, so nothing enters; S refills M when M drains
            if (out_fire) begin
                s_valid    <= 1'b0;
                in_ready_q <= 1'b1;
            end
        end else if (in_fire) begin
            if (!m_valid || out_ready) begin
                m_valid <= 1'b1;
            end else begin
                s_valid    <= 1'b1;
                in_ready_q <= 1'b0;
            end
        end else if (out_fire) begin
            m_valid <= 1'b0;
        end
    end

    // Payload registers; M keeps its last contents when it empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= '0;
            s_q <= '0;
        end else if (s_valid) begin
            if (out_fire) begin
                m_q <= s_q;
            end
        end else if (in_fire) begin
            if (!m_valid || out_ready) begin
                m_q <= dec_e;
            end else begin
                s_q <= dec_e;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_valid;
    assign d         = m_q.d;
    assign sa        = m_q.sa;
    assign right     = m_q.right;
    assign arith     = m_q.arith;
    assign out_rd    = m_q.rd;
    assign out_illeg = m_q.illeg;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Testbench for shift_issue_stage: directed cases, a stall/skid case, a random
// stream against a reference model, and an asynchronous reset with both slots full.
module tb_shift_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [5:0]  in_func;
    logic [4:0]  in_shamt;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic [4:0]  sa;
    logic        right;
    logic        arith;
    logic [4:0]  out_rd;
    logic        out_illeg;

    shift_issue_stage #(.DW(32), .SAW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_func   (in_func),
        .in_shamt  (in_shamt),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .sa        (sa),
        .right     (right),
        .arith     (arith),
        .out_rd    (out_rd),
        .out_illeg (out_illeg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  sa;
        logic        right;
        logic        arith;
        logic [4:0]  rd;
        logic        illeg;
        logic [31:0] sh;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   dut_acc = 0;       // input transfers seen on the DUT ports
    int   dut_out = 0;       // output transfers seen on the DUT ports
    int   model_in = 0;      // entries pushed into the model
    logic last_in_fire = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: what the shifter should produce, from the instruction fields
    function automatic exp_t ref_model(input logic [5:0] op, input logic [5:0] func,
                                       input logic [4:0] shamt, input logic [31:0] rs,
                                       input logic [31:0] rt, input logic [4:0] rd);
        exp_t        e;
        bit          legal;
        bit          is_var;
        bit          is_right;
        bit          is_arith;
        int          amt;
        logic [63:0] wide;
        logic [31:0] pow;
        legal = 0; is_var = 0; is_right = 0; is_arith = 0;
        if (op == 6'd0) begin
            case (func)
                6'd0: begin legal = 1; end
                6'd2: begin legal = 1; is_right = 1; end
                6'd3: begin legal = 1; is_right = 1; is_arith = 1; end
                6'd4: begin legal = 1; is_var = 1; end
                6'd6: begin legal = 1; is_var = 1; is_right = 1; end
                6'd7: begin legal = 1; is_var = 1; is_right = 1; is_arith = 1; end
                default: legal = 0;
            endcase
        end
        e = '0;
        e.d  = rt;
        e.rd = rd;
        if (!legal) begin
            e.illeg = 1'b1;
            e.sh    = rt;
            return e;
        end
        amt = is_var ? int'(rs % 32'd32) : int'(shamt);
        e.sa    = amt[4:0];
        e.right = is_right;
        e.arith = is_arith;
        pow = 32'd1 << amt;
        if (!is_right) begin
            wide = {32'd0, rt} * {32'd0, pow};
            e.sh = wide[31:0];
        end else if (is_arith && rt[31]) begin
            e.sh = ~((~rt) / pow);
        end else begin
            e.sh = rt / pow;
        end
        return e;
    endfunction

    // Behaviour of the downstream barrel shifter driven by the stage outputs
    function automatic logic [31:0] shifter(input logic [31:0] dd, input logic [4:0] s,
                                            input logic r, input logic a);
        logic signed [31:0] sd;
        sd = dd;
        if (!r) return dd << s;
        if (a) return sd >>> s;
        return dd >> s;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [5:0] op, input logic [5:0] func, input logic [4:0] shamt,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
        in_valid = 1'b1;
        in_op    = op;
        in_func  = func;
        in_shamt = shamt;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
    endtask

    task automatic drive_random();
        logic [5:0] funcs [6];
        funcs = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
        drive(($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'd0,
              ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : funcs[$urandom_range(0, 5)],
              5'($urandom_range(0, 31)), $urandom, $urandom, 5'($urandom_range(0, 31)));
    endtask

    // One clock: check outputs against the model at the falling edge, then advance
    task automatic tick();
        logic exp_ready;
        logic exp_valid;
        logic in_fire;
        logic out_fire;
        exp_t f;
        @(negedge clk);
        exp_ready = exp_q.size() < 2;
        exp_valid = exp_q.size() > 0;
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            f = exp_q[0];
            check("d", 64'(d), 64'(f.d));
            check("sa", 64'(sa), 64'(f.sa));
            check("right", 64'(right), 64'(f.right));
            check("arith", 64'(arith), 64'(f.arith));
            check("out_rd", 64'(out_rd), 64'(f.rd));
            check("out_illeg", 64'(out_illeg), 64'(f.illeg));
            check("sh", 64'(shifter(d, sa, right, arith)), 64'(f.sh));
        end
        if (in_valid && in_ready) dut_acc++;
        if (out_valid && out_ready) dut_out++;
        in_fire  = in_valid & exp_ready;
        out_fire = exp_valid & out_ready;
        if (out_fire) void'(exp_q.pop_front());
        if (in_fire) begin
            exp_q.push_back(ref_model(in_op, in_func, in_shamt, in_rs, in_rt, in_rd));
            model_in++;
        end
        last_in_fire = in_fire;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        check("drained", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc0;
        int out0;
        int accepted;
        int cycles;
        in_valid = 1'b0; in_op = '0; in_func = '0; in_shamt = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; out_ready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({d, sa, right, arith, out_rd, out_illeg}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // sll rt=1 shamt=4, accepted on the first edge after reset
        out_ready = 1'b1;
        drive(6'd0, 6'd0, 5'd4, 32'd0, 32'h0000_0001, 5'd3);
        tick();
        in_valid = 1'b0;
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_d", 64'(d), 64'h1);
        check("t1_sa", 64'(sa), 64'd4);
        check("t1_right", 64'(right), 64'd0);
        check("t1_sh", 64'(shifter(d, sa, right, arith)), 64'h10);
        tick();

        // srav with rs=36: only the low five bits count
        drive(6'd0, 6'd7, 5'd0, 32'd36, 32'h8000_0000, 5'd5);
        tick();
        in_valid = 1'b0;
        check("t2_sa", 64'(sa), 64'd4);
        check("t2_right", 64'(right), 64'd1);
        check("t2_arith", 64'(arith), 64'd1);
        check("t2_sh", 64'(shifter(d, sa, right, arith)), 64'hF800_0000);
        tick();

        // add is not a shift: illegal, rt passes through
        drive(6'd0, 6'h20, 5'd9, 32'd7, 32'h1234_5678, 5'd6);
        tick();
        in_valid = 1'b0;
        check("t3_illeg", 64'(out_illeg), 64'd1);
        check("t3_sa", 64'(sa), 64'd0);
        check("t3_sh", 64'(shifter(d, sa, right, arith)), 64'h1234_5678);
        drain();

        // Stall: three back-to-back inputs with out_ready low
        out_ready = 1'b0;
        acc0 = dut_acc;
        out0 = dut_out;
        for (int i = 0; i < 3; i++) begin
            if (!in_valid || last_in_fire) drive_random();
            tick();
        end
        check("t4_accepted", 64'(dut_acc - acc0), 64'd2);
        check("t4_in_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && in_valid && !last_in_fire; i++) tick();
        in_valid = 1'b0;
        drain();
        check("t4_emerged", 64'(dut_out - out0), 64'd3);

        // Random stream of 100 entries with random backpressure
        accepted = 0;
        cycles = 0;
        in_valid = 1'b0;
        last_in_fire = 1'b0;
        while (accepted < 100 && cycles < 3000) begin
            if (!in_valid || last_in_fire) begin
                if ($urandom_range(0, 3) != 0) drive_random();
                else in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (last_in_fire) accepted++;
            cycles++;
        end
        check("t5_accepted", 64'(accepted), 64'd100);
        drain();

        // Fill M and S, then assert reset mid-cycle
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_random();
            tick();
        end
        in_valid = 1'b0;
        check("t6_full", 64'(in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_in_ready", 64'(in_ready), 64'd1);
        check("t6_outputs", 64'({d, sa, right, arith, out_rd, out_illeg}), 64'd0);
        exp_q.delete();
        model_in -= 2;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        drive(6'd0, 6'd2, 5'd8, 32'd0, 32'hABCD_0000, 5'd9);
        tick();
        in_valid = 1'b0;
        check("t6_first_after_rst", 64'(out_valid), 64'd1);
        check("t6_sh", 64'(shifter(d, sa, right, arith)), 64'h00AB_CD00);
        drain();

        check("total_transfers", 64'(dut_out), 64'(model_in));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
